subtractor_serial: RTL and testbench
====================================

# subtractor_serial

Multi-cycle unsigned/two's-complement subtractor computing o_D = i_A − i_B with a borrow-out flag. It processes DIGIT bits per clock from LSB to MSB, using a registered borrow chain. It is the inverse-operation companion to the team's combinational 32-bit adder and is used where area matters more than latency. It has valid/ready handshakes on both input and output, so it can sit between pipeline stages of the arithmetic datapath.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; N = WIDTH/DIGIT RUN cycles per operation.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_valid  in  1  operands present on i_A/i_B.
- o_ready  out  1  block can accept operands; high only in IDLE.
- i_A  in  WIDTH  minuend.
- i_B  in  WIDTH  subtrahend.
- o_valid  out  1  result present; high only in DONE.
- i_ready  in  1  downstream accepts result.
- o_D  out  WIDTH  difference, i_A − i_B mod 2^WIDTH.
- o_Bout  out  1  final borrow; 1 iff i_A < i_B as unsigned.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: o_ready=1. On an edge where i_valid&&o_ready, the block:
  - latches i_A and i_B into operand registers;
  - clears the borrow register and the digit counter (width clog2(N), counts 0..N−1);
  - moves to RUN.
- RUN: on each edge, digit k=counter is computed:
  - {borrow_next, diff_k} = {1'b0, A[k]} − {1'b0, B[k]} − borrow, at DIGIT+1 bits;
  - the borrow out of the digit is the MSB of that (DIGIT+1)-bit result;
  - diff_k is written into result bits [k*DIGIT +: DIGIT];
  - borrow is updated and the counter increments.
  - On the edge where counter==N−1, the final digit is written, o_D/o_Bout are loaded from the result/borrow, and the state moves to DONE.
- DONE: o_valid=1, with o_D and o_Bout stable. On an edge where i_ready=1, the state moves to IDLE. The block holds indefinitely while i_ready=0.
- i_valid is ignored outside IDLE. Operands are sampled only at the accept edge, so later changes on i_A/i_B have no effect.
- o_D/o_Bout keep the last completed result through IDLE and RUN and change only on entry to DONE.
- Signed use: o_D is the correct two's-complement difference. Signed overflow is not flagged.
- Reset (i_rst=1 at an edge, any state, including mid-RUN):
  - state → IDLE, counter → 0, borrow → 0;
  - o_D → 0, o_Bout → 0, o_valid → 0;
  - an in-flight operation is discarded and never produces o_valid.
- i_rst has priority over all handshakes in the same cycle.

## Timing
- Reset values, visible in the cycle after the reset edge: o_ready=1, o_valid=0, o_D=0, o_Bout=0.
- Latency: o_valid rises N edges after the accept edge. With the defaults, that is 8 cycles.
- Result handoff is the edge with o_valid&&i_ready. o_ready is high in the following cycle.
- No accept can occur in the same cycle as a handoff, because o_ready=0 in DONE. Minimum initiation interval is N+2 cycles (10 with defaults).
- o_ready and o_valid are decoded directly from the state register (glitch-free, no combinational path from inputs). There is no input-to-output combinational path.
- Critical path: one DIGIT-bit subtract plus the borrow register. Nothing is WIDTH-wide except the register loads.

## Test plan
- Basic: accept A=5, B=3.
  - Requires o_valid exactly 8 cycles after accept.
  - Requires o_D=0x00000002, o_Bout=0.
- Borrow/wrap: A=3, B=5 → o_D=0xFFFFFFFE, o_Bout=1.
- Full borrow ripple across all digits:
  - A=0x00000000, B=0x00000001 → o_D=0xFFFFFFFF, o_Bout=1.
  - A=0x80000000, B=1 → o_D=0x7FFFFFFF, o_Bout=0.
- Handshake:
  - hold i_ready=0 for 5 cycles in DONE; o_D/o_Bout must stay stable;
  - toggle i_valid and change i_A/i_B during RUN; the result must be unaffected;
  - o_ready must return 1 the cycle after handoff;
  - a back-to-back second operation (0xFFFFFFFF − 0xFFFFFFFF) must give 0, o_Bout=0.
- Reset mid-operation: assert i_rst for 1 cycle at RUN digit 4 of A=10, B=20.
  - Next cycle requires o_ready=1, o_valid=0, o_D=0, o_Bout=0.
  - No o_valid may appear; a new operation 7−7 must give 0 with normal latency.
- Random: 1000 random operand pairs with random i_ready stalls, checked against (A−B) mod 2^32 and A<B; also rerun with DIGIT=1 and DIGIT=8 (latency 32 and 4).

Source files
------------

// File: rtl/subtractor_serial_if.sv
// rtl/subtractor_serial_if.sv - operand/result handshake bundle for subtractor_serial
interface subtractor_serial_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_A;
   logic [WIDTH-1:0] i_B;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_D;
   logic             o_Bout;

   modport slave (
      input  i_valid, i_A, i_B, i_ready,
      output o_ready, o_valid, o_D, o_Bout
   );

   modport master (
      output i_valid, i_A, i_B, i_ready,
      input  o_ready, o_valid, o_D, o_Bout
   );
endinterface

// File: rtl/subtractor_serial.sv
// rtl/subtractor_serial.sv - digit-serial subtractor, D = A - B with borrow-out
// Processes DIGIT bits per cycle LSB first; operands shift right, result shifts in from the top.
module subtractor_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   subtractor_serial_if.slave  bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic [DIGIT:0]   digit;
   logic             last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.i_valid) state_d = RUN;
         RUN:     if (last)        state_d = DONE;
         DONE:    if (bus.i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Current digit always sits in the low DIGIT bits of the shifting operand registers.
   always_comb begin
      digit    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
      last     = (cnt_q == CW'(N - 1));
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      d_d      = d_q;
      bout_d   = bout_q;
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               a_d      = bus.i_A;
               b_d      = bus.i_B;
               borrow_d = 1'b0;
               cnt_d    = '0;
            end
         end
         RUN: begin
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            res_d    = {digit[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
            borrow_d = digit[DIGIT];
            cnt_d    = last ? '0 : cnt_q + CW'(1);
            if (last) begin
               d_d    = res_d;
               bout_d = digit[DIGIT];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.o_ready = (state_q == IDLE);
      bus.o_valid = (state_q == DONE);
      bus.o_D     = d_q;
      bus.o_Bout  = bout_q;
   end
endmodule

// File: tb/tb_subtractor_serial.sv
// tb/tb_subtractor_serial.sv - self-checking bench for subtractor_serial (DIGIT = 4, 1, 8)
module tb_subtractor_serial;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        rdy;
   logic [31:0] a_in, b_in;
   int          sel;
   logic        o_ready, o_valid, o_Bout;
   logic [31:0] o_D;
   logic [31:0] last_d;
   logic        last_b;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   subtractor_serial_if #(.WIDTH(32)) bus4 ();
   subtractor_serial_if #(.WIDTH(32)) bus1 ();
   subtractor_serial_if #(.WIDTH(32)) bus8 ();

   assign bus4.i_valid = valid && (sel == 0);
   assign bus1.i_valid = valid && (sel == 1);
   assign bus8.i_valid = valid && (sel == 2);
   assign bus4.i_ready = rdy && (sel == 0);
   assign bus1.i_ready = rdy && (sel == 1);
   assign bus8.i_ready = rdy && (sel == 2);
   assign bus4.i_A = a_in;
   assign bus1.i_A = a_in;
   assign bus8.i_A = a_in;
   assign bus4.i_B = b_in;
   assign bus1.i_B = b_in;
   assign bus8.i_B = b_in;

   subtractor_serial #(.WIDTH(32), .DIGIT(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));
   subtractor_serial #(.WIDTH(32), .DIGIT(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
   subtractor_serial #(.WIDTH(32), .DIGIT(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(bus8));

   always_comb begin
      o_ready = bus4.o_ready;
      o_valid = bus4.o_valid;
      o_D     = bus4.o_D;
      o_Bout  = bus4.o_Bout;
      if (sel == 1) begin
         o_ready = bus1.o_ready;
         o_valid = bus1.o_valid;
         o_D     = bus1.o_D;
         o_Bout  = bus1.o_Bout;
      end else if (sel == 2) begin
         o_ready = bus8.o_ready;
         o_valid = bus8.o_valid;
         o_D     = bus8.o_D;
         o_Bout  = bus8.o_Bout;
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        bo;
      int          stall;
      bit          perturb;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d)", name, act, exp, sel);
      end
   endtask

   // One full operation: accept, wait for result, optional DONE stall, handoff.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_b,
                        input int stall, input int exp_lat, input bit perturb);
      int t;
      int lat;
      bit hold_ok;
      t = 0;
      while (o_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_op", o_ready, 1);
      valid = 1'b1;
      a_in  = a;
      b_in  = b;
      @(negedge clk);
      lat     = 0;
      hold_ok = 1'b1;
      while (o_valid !== 1'b1 && lat < 200) begin
         if (o_D !== last_d || o_Bout !== last_b || o_ready !== 1'b0) hold_ok = 1'b0;
         if (perturb) begin
            valid = 1'($urandom % 2);
            a_in  = $urandom;
            b_in  = $urandom;
         end else begin
            valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      valid = 1'b0;
      chk("latency", lat, exp_lat);
      chk("hold_through_run", hold_ok, 1);
      chk("diff", o_D, exp_d);
      chk("borrow", o_Bout, exp_b);
      hold_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (o_D !== exp_d || o_Bout !== exp_b || o_valid !== 1'b1) hold_ok = 1'b0;
      end
      if (stall > 0) chk("hold_in_done", hold_ok, 1);
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      chk("ready_after_handoff", o_ready, 1);
      chk("valid_after_handoff", o_valid, 0);
      last_d = exp_d;
      last_b = exp_b;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      int          lats[3];
      int          nops[3];
      bit          seen;

      lats[0] = 8;    lats[1] = 32;  lats[2] = 4;
      nops[0] = 1000; nops[1] = 200; nops[2] = 300;

      tbl[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 5, 1'b1};
      tbl[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 0, 1'b1};
      tbl[2] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 2, 1'b0};
      tbl[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 0, 1'b1};
      tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 1'b0};
      tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1, 1'b1};
      tbl[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1'b0};
      tbl[7] = '{32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b1, 3, 1'b1};
      tbl[8] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 0, 1'b0};

      rst = 1'b1; valid = 1'b0; rdy = 1'b0; sel = 0;
      a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", o_ready, 1);
      chk("reset_valid", o_valid, 0);
      chk("reset_d", o_D, 0);
      chk("reset_bout", o_Bout, 0);
      last_d = '0;
      last_b = 1'b0;

      for (int i = 0; i < 9; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].stall, 8, tbl[i].perturb);

      // Reset while the counter is at digit 4 of 10 - 20.
      valid = 1'b1; a_in = 32'd10; b_in = 32'd20;
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_reset_ready", o_ready, 1);
      chk("midrun_reset_valid", o_valid, 0);
      chk("midrun_reset_d", o_D, 0);
      chk("midrun_reset_bout", o_Bout, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_valid !== 1'b0) seen = 1'b1;
      end
      chk("no_valid_after_reset", seen, 0);
      last_d = '0;
      last_b = 1'b0;
      do_op(32'd7, 32'd7, 32'd0, 1'b0, 0, 8, 1'b0);

      for (int s = 0; s < 3; s++) begin
         sel = s;
         if (s != 0) begin
            last_d = '0;
            last_b = 1'b0;
         end
         for (int i = 0; i < nops[s]; i++) begin
            ra = ($urandom % 8 == 0) ? 32'h0 : $urandom;
            rb = ($urandom % 8 == 1) ? 32'hFFFF_FFFF : $urandom;
            do_op(ra, rb, ra - rb, (ra < rb), $urandom_range(0, 3), lats[s], 1'($urandom % 2));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
